rgb_to_ycbcr_pipe: RTL and testbench

Pipelined, parametrised RGB→YCbCr colour-space converter for the D8M camera path in the color tracker. Accepts one RGB pixel per beat on a valid/ready stream and produces Y, Cb, Cr three cycles later. It supports BT.601 studio-range and full-range (JPEG) coefficient sets selected per pixel, and adds round-half-up rounding and optional range clamping. Upstream it takes the demosaiced RGB stream; downstream it feeds the colour-threshold and tracking logic with full backpressure.

---
 rtl/rgb_to_ycbcr_pipe_if.sv | 29 ++
 rtl/rgb_to_ycbcr_pipe.sv | 148 ++++++++++++++
 tb/tb_rgb_to_ycbcr_pipe.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_to_ycbcr_pipe_if.sv
// Valid/ready stream bundle for rgb_to_ycbcr_pipe: RGB pixels in, YCbCr pixels out.
// The master side drives pixels and iREADY; the slave (converter) drives results and oREADY.
interface rgb_to_ycbcr_pipe_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] iR;
    logic [DATA_W-1:0] iG;
    logic [DATA_W-1:0] iB;
    logic              iMODE;
    logic              iLAST;
    logic              iVALID;
    logic              oREADY;
    logic [DATA_W-1:0] oY;
    logic [DATA_W-1:0] oCb;
    logic [DATA_W-1:0] oCr;
    logic              oLAST;
    logic              oVALID;
    logic              iREADY;

    modport master (
        output iR, iG, iB, iMODE, iLAST, iVALID, iREADY,
        input  oREADY, oY, oCb, oCr, oLAST, oVALID
    );

    modport slave (
        input  iR, iG, iB, iMODE, iLAST, iVALID, iREADY,
        output oREADY, oY, oCb, oCr, oLAST, oVALID
    );
endinterface

// File: rtl/rgb_to_ycbcr_pipe.sv
// Three-stage RGB -> YCbCr converter, BT.601 studio or full range chosen per pixel.
// Define YCBCR_CLAMP_EN to saturate results; otherwise results wrap to DATA_W bits.
module rgb_to_ycbcr_pipe #(
    parameter int unsigned DATA_W = 8
) (
    input logic                iCLK,
    input logic                iRST,
    rgb_to_ycbcr_pipe_if.slave bus
);
    localparam int unsigned PROD_W = DATA_W + 8;
    localparam int unsigned ACC_W  = DATA_W + 10;
    localparam int unsigned SCALE  = DATA_W - 8;

    localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(128);
    localparam logic signed [ACC_W-1:0] OFF_Y = ACC_W'(16 << SCALE);
    localparam logic signed [ACC_W-1:0] OFF_C = ACC_W'(128 << SCALE);

    // Constant-coefficient product built from shifted copies of x.
    function automatic logic [PROD_W-1:0] shAdd(input logic [DATA_W-1:0] x, input logic [7:0] k);
        logic [PROD_W-1:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) p = p + (PROD_W'(x) << i);
        end
        return p;
    endfunction

`ifdef YCBCR_CLAMP_EN
    localparam logic signed [ACC_W-1:0] LO_S  = ACC_W'(16 << SCALE);
    localparam logic signed [ACC_W-1:0] HI_SY = ACC_W'(235 << SCALE);
    localparam logic signed [ACC_W-1:0] HI_SC = ACC_W'(240 << SCALE);
    localparam logic signed [ACC_W-1:0] HI_F  = ACC_W'(255 << SCALE);

    function automatic logic [DATA_W-1:0] fit(input logic signed [ACC_W-1:0] v,
                                               input logic signed [ACC_W-1:0] lo,
                                               input logic signed [ACC_W-1:0] hi);
        if (v < lo) return DATA_W'(lo);
        if (v > hi) return DATA_W'(hi);
        return DATA_W'(v);
    endfunction
`else
    function automatic logic [DATA_W-1:0] fit(input logic signed [ACC_W-1:0] v);
        return DATA_W'(v);
    endfunction
`endif

    logic en;
    assign en         = ~bus.oVALID | bus.iREADY;
    assign bus.oREADY = en;

    // Stage 1: coefficient magnitudes times each component, mode-selected.
    logic [PROD_W-1:0] pYr, pYg, pYb, pCbR, pCbG, pCbB, pCrR, pCrG, pCrB;
    logic              v1, mode1, last1;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v1    <= 1'b0;
            mode1 <= 1'b0;
            last1 <= 1'b0;
            pYr   <= '0;
            pYg   <= '0;
            pYb   <= '0;
            pCbR  <= '0;
            pCbG  <= '0;
            pCbB  <= '0;
            pCrR  <= '0;
            pCrG  <= '0;
            pCrB  <= '0;
        end else if (en) begin
            v1    <= bus.iVALID;
            mode1 <= bus.iMODE;
            last1 <= bus.iLAST;
            pYr   <= bus.iMODE ? shAdd(bus.iR, 8'd77)  : shAdd(bus.iR, 8'd66);
            pYg   <= bus.iMODE ? shAdd(bus.iG, 8'd150) : shAdd(bus.iG, 8'd129);
            pYb   <= bus.iMODE ? shAdd(bus.iB, 8'd29)  : shAdd(bus.iB, 8'd25);
            pCbR  <= bus.iMODE ? shAdd(bus.iR, 8'd43)  : shAdd(bus.iR, 8'd38);
            pCbG  <= bus.iMODE ? shAdd(bus.iG, 8'd85)  : shAdd(bus.iG, 8'd74);
            pCbB  <= bus.iMODE ? shAdd(bus.iB, 8'd128) : shAdd(bus.iB, 8'd112);
            pCrR  <= bus.iMODE ? shAdd(bus.iR, 8'd128) : shAdd(bus.iR, 8'd112);
            pCrG  <= bus.iMODE ? shAdd(bus.iG, 8'd107) : shAdd(bus.iG, 8'd94);
            pCrB  <= bus.iMODE ? shAdd(bus.iB, 8'd21)  : shAdd(bus.iB, 8'd18);
        end
    end

    // Stage 2: signed weighted sums with the half-LSB rounding constant folded in.
    logic signed [ACC_W-1:0] sY, sCb, sCr;
    logic                    v2, mode2, last2;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v2    <= 1'b0;
            mode2 <= 1'b0;
            last2 <= 1'b0;
            sY    <= '0;
            sCb   <= '0;
            sCr   <= '0;
        end else if (en) begin
            v2    <= v1;
            mode2 <= mode1;
            last2 <= last1;
            sY    <= $signed(ACC_W'(pYr)) + $signed(ACC_W'(pYg)) + $signed(ACC_W'(pYb)) + ROUND;
            sCb   <= $signed(ACC_W'(pCbB)) - $signed(ACC_W'(pCbR)) - $signed(ACC_W'(pCbG)) + ROUND;
            sCr   <= $signed(ACC_W'(pCrR)) - $signed(ACC_W'(pCrG)) - $signed(ACC_W'(pCrB)) + ROUND;
        end
    end

    // Stage 3 datapath: floor shift and range offset; kept signed throughout.
    logic signed [ACC_W-1:0] offY, rY, rCb, rCr;
    logic [DATA_W-1:0]       nY, nCb, nCr;
`ifdef YCBCR_CLAMP_EN
    logic signed [ACC_W-1:0] lo, hiY, hiC;
`endif

    always_comb begin
        offY = mode2 ? '0 : OFF_Y;
        rY   = (sY >>> 8) + offY;
        rCb  = (sCb >>> 8) + OFF_C;
        rCr  = (sCr >>> 8) + OFF_C;
`ifdef YCBCR_CLAMP_EN
        lo   = mode2 ? '0 : LO_S;
        hiY  = mode2 ? HI_F : HI_SY;
        hiC  = mode2 ? HI_F : HI_SC;
        nY   = fit(rY, lo, hiY);
        nCb  = fit(rCb, lo, hiC);
        nCr  = fit(rCr, lo, hiC);
`else
        nY   = fit(rY);
        nCb  = fit(rCb);
        nCr  = fit(rCr);
`endif
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bus.oVALID <= 1'b0;
            bus.oLAST  <= 1'b0;
            bus.oY     <= '0;
            bus.oCb    <= '0;
            bus.oCr    <= '0;
        end else if (en) begin
            bus.oVALID <= v2;
            bus.oLAST  <= last2;
            bus.oY     <= nY;
            bus.oCb    <= nCb;
            bus.oCr    <= nCr;
        end
    end
endmodule

// File: tb/tb_rgb_to_ycbcr_pipe.sv
// Bench for rgb_to_ycbcr_pipe: spec vectors, randomized backpressure stream, reset flush, 10-bit path.
// Expected values follow YCBCR_CLAMP_EN the same way the design build does.
module tb_rgb_to_ycbcr_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb_to_ycbcr_pipe_if #(.DATA_W(8))  bus8 ();
    rgb_to_ycbcr_pipe_if #(.DATA_W(10)) bus10 ();

    rgb_to_ycbcr_pipe #(.DATA_W(8))  u8  (.iCLK(clk), .iRST(rst), .bus(bus8));
    rgb_to_ycbcr_pipe #(.DATA_W(10)) u10 (.iCLK(clk), .iRST(rst), .bus(bus10));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int r, g, b;
        bit mode, last;
        int y, cb, cr;
    } vec_t;

    typedef struct {
        int y, cb, cr;
        bit last;
    } out_t;

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fitM(input int v, input int lo, input int hi, input int dw);
`ifdef YCBCR_CLAMP_EN
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
`else
        return v & ((1 << dw) - 1);
`endif
    endfunction

    // Reference conversion straight from the coefficient tables with integer arithmetic.
    function automatic out_t model(input int r, input int g, input int b, input bit mode,
                                   input bit last, input int dw);
        out_t o;
        int s;
        s = 1 << (dw - 8);
        if (!mode) begin
            o.y  = ((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16 * s;
            o.cb = ((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128 * s;
            o.cr = ((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128 * s;
            o.y  = fitM(o.y, 16 * s, 235 * s, dw);
            o.cb = fitM(o.cb, 16 * s, 240 * s, dw);
            o.cr = fitM(o.cr, 16 * s, 240 * s, dw);
        end else begin
            o.y  = ((77 * r + 150 * g + 29 * b + 128) >>> 8);
            o.cb = ((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128 * s;
            o.cr = ((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128 * s;
            o.y  = fitM(o.y, 0, 255 * s, dw);
            o.cb = fitM(o.cb, 0, 255 * s, dw);
            o.cr = fitM(o.cr, 0, 255 * s, dw);
        end
        o.last = last;
        return o;
    endfunction

    // One beat into an idle 8-bit pipe; reports the cycle count until oVALID and the result.
    task automatic sendOne8(input int r, input int g, input int b, input bit mode, input bit last,
                            output out_t o, output int lat);
        @(negedge clk);
        bus8.iR     = 8'(r);
        bus8.iG     = 8'(g);
        bus8.iB     = 8'(b);
        bus8.iMODE  = mode;
        bus8.iLAST  = last;
        bus8.iVALID = 1'b1;
        bus8.iREADY = 1'b1;
        @(negedge clk);
        bus8.iVALID = 1'b0;
        lat = 1;
        while (!bus8.oVALID && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        o.y    = int'(bus8.oY);
        o.cb   = int'(bus8.oCb);
        o.cr   = int'(bus8.oCr);
        o.last = bus8.oLAST;
    endtask

    task automatic sendOne10(input int r, input int g, input int b, input bit mode,
                             output out_t o, output int lat);
        @(negedge clk);
        bus10.iR     = 10'(r);
        bus10.iG     = 10'(g);
        bus10.iB     = 10'(b);
        bus10.iMODE  = mode;
        bus10.iLAST  = 1'b0;
        bus10.iVALID = 1'b1;
        bus10.iREADY = 1'b1;
        @(negedge clk);
        bus10.iVALID = 1'b0;
        lat = 1;
        while (!bus10.oVALID && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        o.y    = int'(bus10.oY);
        o.cb   = int'(bus10.oCb);
        o.cr   = int'(bus10.oCr);
        o.last = bus10.oLAST;
    endtask

    function automatic int packOut();
        return {7'd0, bus8.oLAST, bus8.oY, bus8.oCb, bus8.oCr};
    endfunction

    initial begin
        vec_t vecs[6];
        out_t o, e;
        out_t q[$];
        int   lat;
        int   sent, recv, held;
        bit   haveBeat, prevStall, bm, bl;
        int   br, bg, bb;

`ifdef YCBCR_CLAMP_EN
        vecs[3] = '{r: 255, g: 0, b: 0, mode: 1, last: 1, y: 77, cb: 85, cr: 255};
`else
        vecs[3] = '{r: 255, g: 0, b: 0, mode: 1, last: 1, y: 77, cb: 85, cr: 0};
`endif
        vecs[0] = '{r: 0,   g: 0,   b: 0,   mode: 0, last: 0, y: 16,  cb: 128, cr: 128};
        vecs[1] = '{r: 255, g: 255, b: 255, mode: 0, last: 1, y: 235, cb: 128, cr: 128};
        vecs[2] = '{r: 0,   g: 0,   b: 255, mode: 0, last: 0, y: 41,  cb: 240, cr: 110};
        vecs[4] = '{r: 255, g: 255, b: 255, mode: 1, last: 0, y: 255, cb: 128, cr: 128};
        vecs[5] = '{r: 0,   g: 255, b: 0,   mode: 0, last: 1, y: 144, cb: 54,  cr: 34};

        // Reset state, with a beat offered that must be ignored.
        bus8.iR = 8'd200; bus8.iG = 8'd10; bus8.iB = 8'd99;
        bus8.iMODE = 1'b0; bus8.iLAST = 1'b1; bus8.iVALID = 1'b1; bus8.iREADY = 1'b1;
        bus10.iR = '0; bus10.iG = '0; bus10.iB = '0;
        bus10.iMODE = 1'b0; bus10.iLAST = 1'b0; bus10.iVALID = 1'b0; bus10.iREADY = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("rst_valid", int'(bus8.oVALID), 0);
        checkVal("rst_ready", int'(bus8.oREADY), 1);
        checkVal("rst_data", packOut(), 0);
        bus8.iVALID = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            sendOne8(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].mode, vecs[i].last, o, lat);
            checkVal($sformatf("vec%0d_latency", i), lat, 3);
            checkVal($sformatf("vec%0d_y", i), o.y, vecs[i].y);
            checkVal($sformatf("vec%0d_cb", i), o.cb, vecs[i].cb);
            checkVal($sformatf("vec%0d_cr", i), o.cr, vecs[i].cr);
            checkVal($sformatf("vec%0d_last", i), int'(o.last), int'(vecs[i].last));
        end

        // Randomized stream with gapped input and toggling backpressure.
        sent = 0; recv = 0; haveBeat = 0; prevStall = 0; held = 0;
        br = 0; bg = 0; bb = 0; bm = 0; bl = 0;
        for (int cyc = 0; cyc < 600 && (sent < 16 || q.size() > 0); cyc++) begin
            @(negedge clk);
            if (prevStall) begin
                checkVal("hold_valid", int'(bus8.oVALID), 1);
                checkVal("hold_data", packOut(), held);
            end
            if (!haveBeat && sent < 16 && $urandom_range(0, 3) != 0) begin
                haveBeat = 1;
                br = int'($urandom_range(0, 255));
                bg = int'($urandom_range(0, 255));
                bb = int'($urandom_range(0, 255));
                bm = 1'($urandom_range(0, 1));
                bl = 1'($urandom_range(0, 1));
            end
            bus8.iVALID = haveBeat;
            bus8.iR     = 8'(br);
            bus8.iG     = 8'(bg);
            bus8.iB     = 8'(bb);
            bus8.iMODE  = bm;
            bus8.iLAST  = bl;
            bus8.iREADY = ($urandom_range(0, 2) != 0);
            #1;
            checkVal("stream_oready", int'(bus8.oREADY), int'(!(bus8.oVALID && !bus8.iREADY)));
            if (bus8.oVALID && bus8.iREADY) begin
                checkVal("stream_extra_beat", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    checkVal("stream_y", int'(bus8.oY), e.y);
                    checkVal("stream_cb", int'(bus8.oCb), e.cb);
                    checkVal("stream_cr", int'(bus8.oCr), e.cr);
                    checkVal("stream_last", int'(bus8.oLAST), int'(e.last));
                end
                recv++;
            end
            prevStall = bus8.oVALID && !bus8.iREADY;
            held      = packOut();
            if (haveBeat && bus8.oREADY) begin
                q.push_back(model(br, bg, bb, bm, bl, 8));
                sent++;
                haveBeat = 0;
            end
        end
        @(negedge clk);
        bus8.iVALID = 1'b0;
        bus8.iREADY = 1'b1;
        checkVal("stream_sent", sent, 16);
        checkVal("stream_recv", recv, 16);
        checkVal("stream_pending", int'(q.size()), 0);

        // Reset with three beats in flight, then one clean beat.
        repeat (3) begin
            @(negedge clk);
            bus8.iR = 8'($urandom_range(0, 255));
            bus8.iG = 8'($urandom_range(0, 255));
            bus8.iB = 8'($urandom_range(0, 255));
            bus8.iVALID = 1'b1;
        end
        @(negedge clk);
        bus8.iVALID = 1'b0;
        checkVal("inflight_valid", int'(bus8.oVALID), 1);
        rst = 1'b1;
        #1;
        checkVal("midrst_valid", int'(bus8.oVALID), 0);
        checkVal("midrst_ready", int'(bus8.oREADY), 1);
        checkVal("midrst_data", packOut(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkVal("postrst_idle", int'(bus8.oVALID), 0);
        end
        sendOne8(255, 255, 255, 1'b1, 1'b1, o, lat);
        checkVal("postrst_latency", lat, 3);
        checkVal("postrst_y", o.y, 255);
        checkVal("postrst_cb", o.cb, 128);
        checkVal("postrst_cr", o.cr, 128);

        // 10-bit instance: white in studio range, then a few random pixels.
        sendOne10(1023, 1023, 1023, 1'b0, o, lat);
        checkVal("w10_latency", lat, 3);
`ifdef YCBCR_CLAMP_EN
        checkVal("w10_y", o.y, 940);
`else
        checkVal("w10_y", o.y, 943);
`endif
        checkVal("w10_cb", o.cb, 512);
        checkVal("w10_cr", o.cr, 512);
        repeat (4) begin
            br = int'($urandom_range(0, 1023));
            bg = int'($urandom_range(0, 1023));
            bb = int'($urandom_range(0, 1023));
            bm = 1'($urandom_range(0, 1));
            e  = model(br, bg, bb, bm, 1'b0, 10);
            sendOne10(br, bg, bb, bm, o, lat);
            checkVal("r10_latency", lat, 3);
            checkVal("r10_y", o.y, e.y);
            checkVal("r10_cb", o.cb, e.cb);
            checkVal("r10_cr", o.cr, e.cr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
